// File: rtl/float_align_if.sv
// float_align_if: operand-pair/aligned-result handshake bus for float_align_stage
interface float_align_if #(parameter int EW = 8, parameter int MW = 23);
  localparam int W = MW + 3;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [EW+MW:0] op_a, op_b;
  logic [W-1:0] big_mant, small_mant;
  logic [EW-1:0] big_exp;
  logic result_sign, sub_enable, special_out;
  modport master(
    output in_valid, op_a, op_b, out_ready,
    input in_ready, out_valid, big_mant, small_mant, big_exp, result_sign, sub_enable, special_out
  );
  modport slave(
    input in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, big_mant, small_mant, big_exp, result_sign, sub_enable, special_out
  );
endinterface

// File: rtl/float_align_stage.sv
// float_align_stage: 2-stage magnitude ordering and significand alignment; FLOAT_ALIGN_STICKY_EN folds shifted-out bits into bit 0
module float_align_stage #(parameter int EW = 8, parameter int MW = 23) (
  input logic clk,
  input logic rst,
  float_align_if.slave bus
);
  localparam int W = MW + 3;
  localparam int SW = MW + 1;
  logic [EW-1:0] w_exp_a, w_exp_b, w_eff_a, w_eff_b;
  logic [SW-1:0] w_sig_a, w_sig_b;
  logic w_swap, w_s2_load, w_in_ready;
  logic r1_valid, r1_sign, r1_sub, r1_special;
  logic [SW-1:0] r1_big_sig, r1_small_sig;
  logic [EW-1:0] r1_big_exp, r1_d;
  logic r2_valid, r2_sign, r2_sub, r2_special;
  logic [W-1:0] r2_big_mant, r2_small_mant;
  logic [EW-1:0] r2_big_exp;
  logic [W-1:0] w_s, w_shift, w_small;
`ifdef FLOAT_ALIGN_STICKY_EN
  logic [W-1:0] w_mask;
`endif
  always_comb begin
    w_exp_a = bus.op_a[EW+MW-1:MW];
    w_exp_b = bus.op_b[EW+MW-1:MW];
    w_eff_a = (|w_exp_a) ? w_exp_a : EW'(1);
    w_eff_b = (|w_exp_b) ? w_exp_b : EW'(1);
    w_sig_a = {|w_exp_a, bus.op_a[MW-1:0]};
    w_sig_b = {|w_exp_b, bus.op_b[MW-1:0]};
    w_swap = (w_eff_b > w_eff_a) || (w_eff_b == w_eff_a && w_sig_b > w_sig_a);
    w_s2_load = !r2_valid || bus.out_ready;
    w_in_ready = !r1_valid || w_s2_load;
    w_s = {r1_small_sig, 2'b00};
    w_shift = w_s >> r1_d;
`ifdef FLOAT_ALIGN_STICKY_EN
    w_mask = ~({W{1'b1}} << r1_d);
    w_small = {w_shift[W-1:1], w_shift[0] | (|(w_s & w_mask))};
`else
    w_small = w_shift;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_sign <= 1'b0;
      r1_sub <= 1'b0;
      r1_special <= 1'b0;
      r1_big_sig <= '0;
      r1_small_sig <= '0;
      r1_big_exp <= '0;
      r1_d <= '0;
      r2_valid <= 1'b0;
      r2_sign <= 1'b0;
      r2_sub <= 1'b0;
      r2_special <= 1'b0;
      r2_big_mant <= '0;
      r2_small_mant <= '0;
      r2_big_exp <= '0;
    end else begin
      if (w_in_ready) r1_valid <= bus.in_valid;
      if (w_in_ready && bus.in_valid) begin
        r1_big_sig <= w_swap ? w_sig_b : w_sig_a;
        r1_small_sig <= w_swap ? w_sig_a : w_sig_b;
        r1_big_exp <= w_swap ? w_eff_b : w_eff_a;
        r1_d <= w_swap ? w_eff_b - w_eff_a : w_eff_a - w_eff_b;
        r1_sign <= w_swap ? bus.op_b[EW+MW] : bus.op_a[EW+MW];
        r1_sub <= bus.op_a[EW+MW] ^ bus.op_b[EW+MW];
        r1_special <= (&w_exp_a) | (&w_exp_b);
      end
      if (w_s2_load) r2_valid <= r1_valid;
      if (w_s2_load && r1_valid) begin
        r2_big_mant <= {r1_big_sig, 2'b00};
        r2_small_mant <= w_small;
        r2_big_exp <= r1_big_exp;
        r2_sign <= r1_sign;
        r2_sub <= r1_sub;
        r2_special <= r1_special;
      end
    end
  end
  assign bus.in_ready = w_in_ready;
  assign bus.out_valid = r2_valid;
  assign bus.big_mant = r2_big_mant;
  assign bus.small_mant = r2_small_mant;
  assign bus.big_exp = r2_big_exp;
  assign bus.result_sign = r2_sign;
  assign bus.sub_enable = r2_sub;
  assign bus.special_out = r2_special;
endmodule
